serial_add_ctrl: RTL and testbench

//  Bit-serial add/subtract sequencer built around one full_adder instance.

---
 rtl/serial_add_ctrl.sv | 93 +++++++++
 tb/tb_serial_add_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer around one shared full adder
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_co;
  full_adder u_fa (
    .i_a  (r_a[0]),
    .i_b  (r_b[0]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );
  assign in_ready = (r_state == IDLE);
  // sequencer: capture operands, ripple one bit per clock LSB-first, hold result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= in_a;
          r_b     <= in_sub ? ~in_b : in_b;
          r_carry <= in_sub | in_cin;
          r_cnt   <= '0;
          r_state <= RUN;
          busy    <= 1'b1;
        end
        RUN: begin
          r_res   <= {w_s, r_res[WIDTH-1:1]};
          r_carry <= w_co;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
            out_sum   <= {w_s, r_res[WIDTH-1:1]};
            out_cout  <= w_co;
          end
        end
        DONE: if (out_ready) begin
          r_state   <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed table, handshake corner cases and random ops vs arithmetic model
module tb_serial_add_ctrl;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout, busy;
  logic [W-1:0] in_a, in_b, out_sum;
  int           errors = 0;
  int           checks = 0;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       c;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // waits for in_ready, presents one op for one accepting edge, returns at the negedge after it
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom); in_sub = 1'($urandom);
    chk("busy_after_accept", busy, 1);
  endtask

  // called at the negedge after the accepting edge; counts edges until out_valid
  task automatic wait_result(input string name, input logic [7:0] s, input logic c);
    int lat = 0;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, W);
    chk({name, "_sum"}, out_sum, s);
    chk({name, "_cout"}, out_cout, c);
  endtask

  task automatic handshake(input int delay);
    repeat (delay) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask

  initial begin
    logic [8:0] m;
    logic       seen;
    vecs[0] = '{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0};
    vecs[3] = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1};
    vecs[4] = '{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{8'h7F, 8'h7F, 1'b1, 1'b1, 8'h00, 1'b1};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_result($sformatf("vec%0d", i), vecs[i].s, vecs[i].c);
      handshake(0);
    end
    issue(8'h5A, 8'h33, 1'b0, 1'b0);
    wait_result("bp", 8'h8D, 1'b0);
    in_a = 8'h01; in_b = 8'h02; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", out_sum, 8'h8D);
      chk("bp_cout", out_cout, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accept_busy", busy, 1);
    chk("bp_accept_ready", in_ready, 0);
    wait_result("bp_next", 8'h03, 1'b0);
    handshake(0);
    issue(8'hAA, 8'h11, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_sum", out_sum, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_cout", out_cout, 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("abort_no_result", seen, 0);
    issue(8'h12, 8'h34, 1'b0, 1'b0);
    wait_result("post_abort", 8'h46, 1'b0);
    handshake(1);
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a, b;
      logic       cin, sub;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      if (sub) m = {a >= b, a - b};
      else m = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(a, b, cin, sub);
      wait_result("rand", m[7:0], m[8]);
      handshake($urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
